morse_capture: RTL and testbench

Player-1 input stage for the morse game. Turns a single push-button into dot/dash symbols, measured in sample ticks, and packs up to five symbols into a 10-bit word. On each commit it emits a one-cycle write strobe with the word and a 4-bit address, ready to drive the 16-entry word RAM that player 2 later reads back.

---
 rtl/morse_pkg.sv | 18 +
 rtl/key_conditioner.sv | 74 +++++++
 rtl/morse_capture.sv | 156 +++++++++++++++
 tb/tb_morse_capture.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared symbol codes, FSM state encoding and word geometry for the morse capture stage.
package morse_pkg;

    localparam int WORD_W      = 10;
    localparam int MAX_SYMBOLS = 5;

    localparam logic [1:0] SYM_EMPTY = 2'b00;
    localparam logic [1:0] SYM_DOT   = 2'b01;
    localparam logic [1:0] SYM_DASH  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRESS  = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/key_conditioner.sv
// Button conditioner: 2-flop synchroniser, optional stability filter, registered press pulse.
// The filter is compiled in with MORSE_CAPTURE_DEBOUNCE_EN.
module key_conditioner #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic clock,
    input  logic reset,
    input  logic pin_n,
    output logic level,
    output logic fall
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       fall_q, fall_d;
    logic       stable_n;

`ifdef MORSE_CAPTURE_DEBOUNCE_EN
    logic [19:0] db_cnt_q, db_cnt_d;
    logic        db_lvl_q, db_lvl_d;

    // A change is accepted only once the synchronised pin has disagreed for the whole window.
    always_comb begin
        db_cnt_d = db_cnt_q;
        db_lvl_d = db_lvl_q;
        if (sync_q[1] == db_lvl_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
            db_lvl_d = sync_q[1];
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 20'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            db_cnt_q <= '0;
            db_lvl_q <= 1'b1;
        end else begin
            db_cnt_q <= db_cnt_d;
            db_lvl_q <= db_lvl_d;
        end
    end

    assign stable_n = db_lvl_q;
`else
    logic unused_debounce;
    assign unused_debounce = ^DEBOUNCE_CYCLES;
    assign stable_n        = sync_q[1];
`endif

    always_comb begin
        sync_d = {sync_q[0], pin_n};
        prev_d = stable_n;
        fall_d = prev_q & ~stable_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            fall_q <= fall_d;
        end
    end

    assign level = ~stable_n;
    assign fall  = fall_q;

endmodule

// File: rtl/morse_capture.sv
// Player-1 capture: times key presses into dot/dash symbols, packs them into words and
// strobes each committed word to the word RAM. Debounce via MORSE_CAPTURE_DEBOUNCE_EN.
module morse_capture #(
    parameter int          DASH_TICKS      = 3,
    parameter int          MAX_SYMBOLS     = 5,
    parameter int          DEPTH           = 16,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       enable,
    input  logic       key_n,
    input  logic       next_n,
    input  logic       done_n,
    output logic [9:0] q,
    output logic       write,
    output logic [3:0] addr,
    output logic [2:0] count,
    output logic       full,
    output logic       finished
);

    import morse_pkg::*;

    localparam int               DUR_W     = $clog2(DASH_TICKS + 1);
    localparam logic [DUR_W-1:0] DUR_DASH  = DUR_W'(DASH_TICKS);
    localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
    localparam logic [2:0]       MAX_CNT   = 3'(MAX_SYMBOLS);
    localparam logic [3:0]       LAST_ADDR = 4'(DEPTH - 1);

    logic key_level, next_fall, done_fall;
    logic key_fall_unused, next_level_unused, done_level_unused;

    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clock(clock), .reset(reset), .pin_n(key_n),
        .level(key_level), .fall(key_fall_unused)
    );
    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clock(clock), .reset(reset), .pin_n(next_n),
        .level(next_level_unused), .fall(next_fall)
    );
    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_done (
        .clock(clock), .reset(reset), .pin_n(done_n),
        .level(done_level_unused), .fall(done_fall)
    );

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [2:0]        count_q, count_d;
    logic [3:0]        addr_q, addr_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              write_q, write_d;
    logic              full_q, full_d;
    logic              finished_q, finished_d;
    logic              done_pend_q, done_pend_d;
    logic [1:0]        sym;
    logic              can_commit;

    assign sym        = (dur_q >= DUR_DASH) ? SYM_DASH : SYM_DOT;
    assign can_commit = (count_q != 3'd0) && !full_q;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        count_d     = count_q;
        addr_d      = addr_q;
        dur_d       = dur_q;
        write_d     = 1'b0;
        full_d      = full_q;
        finished_d  = finished_q;
        done_pend_d = done_pend_q;
        unique case (state_q)
            S_IDLE, S_PRESS: begin
                if (!enable) begin
                    // Leaving the turn mid-press throws the partial duration away.
                    state_d = S_IDLE;
                end else if (done_fall) begin
                    if (can_commit) begin
                        state_d     = S_COMMIT;
                        write_d     = 1'b1;
                        done_pend_d = 1'b1;
                    end else begin
                        state_d    = S_DONE;
                        finished_d = 1'b1;
                    end
                end else if (state_q == S_IDLE) begin
                    if (next_fall && can_commit) begin
                        state_d = S_COMMIT;
                        write_d = 1'b1;
                    end else if (tick && key_level && count_q < MAX_CNT) begin
                        state_d = S_PRESS;
                        dur_d   = DUR_ONE;
                    end
                end else if (tick) begin
                    if (key_level) begin
                        if (dur_q < DUR_DASH) dur_d = dur_q + DUR_ONE;
                    end else begin
                        word_d  = {word_q[WORD_W-3:0], sym};
                        count_d = count_q + 3'd1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_COMMIT: begin
                addr_d      = addr_q + 4'd1;
                word_d      = '0;
                count_d     = 3'd0;
                done_pend_d = 1'b0;
                if (addr_q == LAST_ADDR) full_d = 1'b1;
                if (done_pend_q || (enable && done_fall)) begin
                    state_d    = S_DONE;
                    finished_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            count_q     <= 3'd0;
            addr_q      <= 4'd0;
            dur_q       <= '0;
            write_q     <= 1'b0;
            full_q      <= 1'b0;
            finished_q  <= 1'b0;
            done_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            dur_q       <= dur_d;
            write_q     <= write_d;
            full_q      <= full_d;
            finished_q  <= finished_d;
            done_pend_q <= done_pend_d;
        end
    end

    assign q        = word_q;
    assign write    = write_q;
    assign addr     = addr_q;
    assign count    = count_q;
    assign full     = full_q;
    assign finished = finished_q;

endmodule

// File: tb/tb_morse_capture.sv
// Scoreboard bench for morse_capture: expected writes are queued by the stimulus and
// popped by an independent write monitor.
module tb_morse_capture;

`ifdef MORSE_CAPTURE_DEBOUNCE_EN
    localparam int SETTLE = 14;
`else
    localparam int SETTLE = 4;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       enable = 1'b0;
    logic       key_n = 1'b1;
    logic       next_n = 1'b1;
    logic       done_n = 1'b1;
    logic [9:0] q;
    logic       write;
    logic [3:0] addr;
    logic [2:0] count;
    logic       full;
    logic       finished;

    int checks = 0;
    int errors = 0;
    logic [13:0] exp_q[$];

    morse_capture #(
        .DASH_TICKS(3), .MAX_SYMBOLS(5), .DEPTH(16), .DEBOUNCE_CYCLES(20'd8)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick), .enable(enable),
        .key_n(key_n), .next_n(next_n), .done_n(done_n),
        .q(q), .write(write), .addr(addr), .count(count),
        .full(full), .finished(finished)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    // Write monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (write) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got q=%b addr=%0d, expected no write", q, addr);
            end else begin
                logic [13:0] e;
                e = exp_q.pop_front();
                if ({q, addr} !== e) begin
                    errors++;
                    $display("FAIL write_data: got q=%b addr=%0d, expected q=%b addr=%0d",
                             q, addr, e[13:4], e[3:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        clk(1);
        tick = 1'b0;
        clk(1);
    endtask

    // Hold the key across n ticks, then release and give the release tick.
    task automatic press(input int n);
        key_n = 1'b0;
        clk(SETTLE);
        repeat (n) pulse_tick();
        key_n = 1'b1;
        clk(SETTLE);
        pulse_tick();
        clk(1);
    endtask

    task automatic hit_next();
        next_n = 1'b0;
        clk(SETTLE + 2);
        next_n = 1'b1;
        clk(SETTLE + 2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clk(2);
        reset = 1'b0;
        clk(1);
    endtask

    initial begin
        clk(3);
        chk("reset_q", int'(q), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_addr", int'(addr), 0);
        chk("reset_write", int'(write), 0);
        chk("reset_full", int'(full), 0);
        chk("reset_finished", int'(finished), 0);
        reset = 1'b0;
        enable = 1'b1;
        clk(2);

        // Dot then dash, committed to address 0.
        press(1);
        press(4);
        chk("dot_dash_count", int'(count), 2);
        chk("dot_dash_q", int'(q), 10'b00_0000_0111);
        exp_q.push_back({10'b00_0000_0111, 4'd0});
        hit_next();
        chk("commit1_addr", int'(addr), 1);
        chk("commit1_q", int'(q), 0);
        chk("commit1_count", int'(count), 0);

        // Six dots: the sixth is ignored.
        repeat (6) press(1);
        chk("sat_count", int'(count), 5);
        chk("sat_q", int'(q), 10'b01_0101_0101);
        exp_q.push_back({10'b01_0101_0101, 4'd1});
        hit_next();
        chk("commit2_addr", int'(addr), 2);

        // Empty word: next is dropped.
        hit_next();
        chk("empty_next_addr", int'(addr), 2);

        // Enable low: presses and next ignored.
        enable = 1'b0;
        press(1);
        chk("disabled_count", int'(count), 0);
        enable = 1'b1;

        // One dot, then next and done together: one write, then finished.
        press(1);
        exp_q.push_back({10'b00_0000_0001, 4'd2});
        next_n = 1'b0;
        done_n = 1'b0;
        clk(SETTLE + 4);
        chk("next_done_finished", int'(finished), 1);
        chk("next_done_addr", int'(addr), 3);
        chk("next_done_count", int'(count), 0);
        next_n = 1'b1;
        done_n = 1'b1;
        clk(SETTLE + 2);

        // Sixteen commits fill the RAM; a seventeenth is blocked.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            press(1);
            exp_q.push_back({10'b00_0000_0001, 4'(i)});
            if (i == 15) chk("full_before_16", int'(full), 0);
            hit_next();
        end
        chk("full_after_16", int'(full), 1);
        chk("addr_after_16", int'(addr), 0);
        press(1);
        hit_next();
        chk("blocked_addr", int'(addr), 0);
        chk("blocked_count", int'(count), 1);

        // Reset while a press is being timed.
        do_reset();
        key_n = 1'b0;
        clk(SETTLE);
        pulse_tick();
        pulse_tick();
        reset = 1'b1;
        clk(1);
        chk("midpress_q", int'(q), 0);
        chk("midpress_count", int'(count), 0);
        chk("midpress_full", int'(full), 0);
        chk("midpress_write", int'(write), 0);
        reset = 1'b0;
        key_n = 1'b1;
        clk(SETTLE);
        pulse_tick();
        clk(2);
        chk("midpress_no_symbol", int'(count), 0);

`ifdef MORSE_CAPTURE_DEBOUNCE_EN
        // Short glitch on next is filtered; a long press commits.
        press(1);
        next_n = 1'b0;
        clk(5);
        next_n = 1'b1;
        clk(20);
        chk("glitch_addr", int'(addr), 0);
        exp_q.push_back({10'b00_0000_0001, 4'd0});
        next_n = 1'b0;
        clk(20);
        next_n = 1'b1;
        clk(20);
        chk("long_next_addr", int'(addr), 1);
`endif

        clk(10);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
